// File: rtl/fwd_pkg.sv
// Shared record type and default constants for the EX-stage forwarding/hazard unit.
package fwd_pkg;
  // Record rd field is sized for the widest supported register index; narrower
  // instances zero-extend into it.
  localparam int REC_REG_W      = 8;
  localparam int ZERO_REG_DEF   = 31;
  localparam int LOAD_READY_DEF = 2;

  typedef struct packed {
    logic                 valid;
    logic [REC_REG_W-1:0] rd;
    logic                 regwrite;
    logic                 is_load;
  } fwd_rec_t;
endpackage

// File: rtl/fwd_match.sv
// Priority comparator: one source register against DEPTH downstream records, youngest wins.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int REG_W    = 5,
  parameter int ZERO_REG = ZERO_REG_DEF,
  parameter int SEL_W    = 2
) (
  input  logic [REG_W-1:0]     src,
  input  fwd_rec_t [DEPTH-1:0] recs,
  output logic [SEL_W-1:0]     sel,
  output logic                 is_load_hit
);
  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    sel         = '0;
    is_load_hit = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (recs[k].valid && recs[k].regwrite &&
          recs[k].rd != REC_REG_W'(ZERO_REG) &&
          recs[k].rd == REC_REG_W'(src)) begin
        sel         = SEL_W'(k + 1);
        is_load_hit = recs[k].is_load;
      end
    end
  end
endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage forwarding select and load-use stall with its own downstream record pipeline.
// Optional statistics counters enabled by defining FWD_HAZARD_STATS_EN.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3,
  parameter int REG_W      = 5,
  parameter int ZERO_REG   = ZERO_REG_DEF,
  parameter int LOAD_READY = LOAD_READY_DEF,
  localparam int SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              advance,
  input  logic                              flush,
  input  logic                              ex_valid,
  input  logic [REG_W-1:0]                  ex_rd,
  input  logic                              ex_regwrite,
  input  logic                              ex_is_load,
  input  logic [NUM_SRC-1:0][REG_W-1:0]     ex_src,
`ifdef FWD_HAZARD_STATS_EN
  output logic [31:0]                       stall_cycles,
  output logic [31:0]                       fwd_events,
`endif
  output logic [NUM_SRC-1:0][SEL_W-1:0]     fwd_sel,
  output logic                              stall
);
  fwd_rec_t [DEPTH-1:0] recs;   // recs[0] = stage 1 (MEM)
  logic [NUM_SRC-1:0]   load_hit;
  logic [NUM_SRC-1:0]   hazard;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    fwd_match #(
      .DEPTH(DEPTH), .REG_W(REG_W), .ZERO_REG(ZERO_REG), .SEL_W(SEL_W)
    ) u_match (
      .src(ex_src[s]),
      .recs(recs),
      .sel(fwd_sel[s]),
      .is_load_hit(load_hit[s])
    );
    assign hazard[s] = load_hit[s] && (int'(fwd_sel[s]) < LOAD_READY);
  end

  assign stall = ex_valid && !flush && (|hazard);

  // A stalled or squashed EX instruction enters stage 1 as a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      recs <= '0;
    end else if (advance) begin
      if (stall || flush) begin
        recs[0] <= '0;
      end else begin
        recs[0] <= '{valid: ex_valid, rd: REC_REG_W'(ex_rd),
                     regwrite: ex_regwrite, is_load: ex_is_load};
      end
      for (int k = 1; k < DEPTH; k++) recs[k] <= recs[k-1];
    end
  end

`ifdef FWD_HAZARD_STATS_EN
  localparam int CNT_W = $clog2(NUM_SRC + 1);
  logic [CNT_W-1:0] n_fwd;
  logic [32:0]      fwd_sum;

  always_comb begin
    n_fwd = '0;
    for (int s = 0; s < NUM_SRC; s++)
      if (fwd_sel[s] != '0) n_fwd = n_fwd + CNT_W'(1);
    fwd_sum = {1'b0, fwd_events} + 33'(n_fwd);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      fwd_events   <= '0;
    end else if (advance) begin
      if (stall) begin
        if (stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
      end else begin
        fwd_events <= fwd_sum[32] ? '1 : fwd_sum[31:0];
      end
    end
  end
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench: random and directed EX traffic against a queue-based model of the pipeline.
module tb_fwd_hazard_unit;
  localparam int NS = 2, D = 3, RW = 5, SW = 2;

  logic clk = 1'b0;
  logic reset, advance, flush, ex_valid, ex_regwrite, ex_is_load;
  logic [RW-1:0] ex_rd;
  logic [NS-1:0][RW-1:0] ex_src;
  logic [NS-1:0][SW-1:0] fwd_sel;
  logic stall;
`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] stall_cycles, fwd_events;
`endif

  always #5 clk = ~clk;

  fwd_hazard_unit dut (
    .clk(clk), .reset(reset), .advance(advance), .flush(flush),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_is_load(ex_is_load), .ex_src(ex_src),
`ifdef FWD_HAZARD_STATS_EN
    .stall_cycles(stall_cycles), .fwd_events(fwd_events),
`endif
    .fwd_sel(fwd_sel), .stall(stall)
  );

  typedef struct {bit v; int rd; bit rw; bit ld;} mrec_t;
  typedef struct {int sel0; int sel1; bit stall; longint sc; longint fe;} exp_t;

  mrec_t  model[$];   // model[0] is the youngest downstream stage
  exp_t   expq[$];
  int     n_cmp = 0, n_bad = 0;
  longint m_sc = 0, m_fe = 0;
  bit     l_rst, l_adv, l_fl, l_st;
  mrec_t  l_rec;
  int     l_sel0, l_sel1;

  task automatic chk(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Youngest producer of src; reports whether it is a load not yet forwardable.
  function automatic int find(int src, output bit haz);
    haz = 0;
    for (int i = 0; i < model.size(); i++)
      if (model[i].v && model[i].rw && model[i].rd != 31 && model[i].rd == src) begin
        haz = model[i].ld && (i + 1) < 2;
        return i + 1;
      end
    return 0;
  endfunction

  task automatic drive(bit rst, bit adv, bit fl, bit v, int rd, bit rw, bit ld, int s0, int s1);
    bit h0, h1;
    exp_t e;
    reset = rst; advance = adv; flush = fl; ex_valid = v;
    ex_rd = RW'(rd); ex_regwrite = rw; ex_is_load = ld;
    ex_src[0] = RW'(s0); ex_src[1] = RW'(s1);
    l_sel0 = find(s0, h0);
    l_sel1 = find(s1, h1);
    l_st = v && !fl && (h0 || h1);
    l_rst = rst; l_adv = adv; l_fl = fl;
    l_rec = '{v, rd, rw, ld};
    e = '{l_sel0, l_sel1, l_st, m_sc, m_fe};
    if (!rst) expq.push_back(e);
  endtask

  task automatic adv_clk();
    mrec_t bub;
    bub = '{0, 0, 0, 0};
    @(posedge clk); #1;
    if (l_rst) begin
      model.delete();
      repeat (D) model.push_back(bub);
      m_sc = 0; m_fe = 0;
    end else if (l_adv) begin
      model.push_front((l_st || l_fl) ? bub : l_rec);
      void'(model.pop_back());
      if (l_st) m_sc = (m_sc < 64'hFFFF_FFFF) ? m_sc + 1 : m_sc;
      else m_fe = m_fe + (l_sel0 != 0) + (l_sel1 != 0) > 64'hFFFF_FFFF ?
                  64'hFFFF_FFFF : m_fe + (l_sel0 != 0) + (l_sel1 != 0);
    end
  endtask

  task automatic dchk(string name, int s0e, int s1e, bit ste);
    #1;
    if (s0e >= 0) chk({name, ".sel0"}, fwd_sel[0], s0e);
    if (s1e >= 0) chk({name, ".sel1"}, fwd_sel[1], s1e);
    chk({name, ".stall"}, stall, ste);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("sb.sel0", fwd_sel[0], e.sel0);
      chk("sb.sel1", fwd_sel[1], e.sel1);
      chk("sb.stall", stall, e.stall);
`ifdef FWD_HAZARD_STATS_EN
      chk("sb.stall_cycles", stall_cycles, e.sc);
      chk("sb.fwd_events", fwd_events, e.fe);
`endif
    end
  end

  initial begin
    for (int i = 0; i < D; i++) model.push_back('{0, 0, 0, 0});
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); adv_clk();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); adv_clk();
    drive(0, 0, 0, 1, 2, 1, 1, 2, 3); dchk("reset", 0, 0, 0); adv_clk();

    // Simple forward from stage 1
    drive(0, 1, 0, 1, 3, 1, 0, 0, 0); adv_clk();
    drive(0, 0, 0, 0, 0, 0, 0, 3, 4); dchk("fwd_s1", 1, 0, 0); adv_clk();
    // Youngest wins
    drive(0, 1, 0, 1, 5, 1, 0, 0, 0); adv_clk();
    drive(0, 1, 0, 1, 5, 1, 0, 0, 0); adv_clk();
    drive(0, 0, 0, 1, 0, 0, 0, 5, 0); dchk("youngest", 1, 0, 0); adv_clk();
    // Load-use: one stall cycle, then forward from stage 2
    drive(0, 1, 0, 1, 7, 1, 1, 0, 0); adv_clk();
    drive(0, 1, 0, 1, 1, 1, 0, 0, 7); dchk("lu_stall", 0, 1, 1); adv_clk();
    drive(0, 1, 0, 1, 1, 1, 0, 0, 7); dchk("lu_after", 0, 2, 0); adv_clk();
    // Zero register and non-writing producer
    drive(0, 1, 0, 1, 31, 1, 0, 0, 0); adv_clk();
    drive(0, 0, 0, 1, 0, 0, 0, 31, 0); dchk("zero_reg", 0, 0, 0); adv_clk();
    drive(0, 1, 0, 1, 9, 0, 0, 0, 0); adv_clk();
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0); adv_clk();
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0); adv_clk();
    drive(0, 0, 0, 1, 0, 0, 0, 9, 9); dchk("no_regwrite", 0, 0, 0); adv_clk();
    // Flush overrides hazard
    drive(0, 1, 0, 1, 7, 1, 1, 0, 0); adv_clk();
    drive(0, 1, 1, 1, 8, 1, 0, 0, 7); dchk("flush", 0, 1, 0); adv_clk();
    drive(0, 0, 0, 0, 0, 0, 0, 8, 7); dchk("flush_bubble", 0, 2, 0); adv_clk();
    // Freeze with hazard pending
    drive(0, 1, 0, 1, 6, 1, 1, 0, 0); adv_clk();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 0, 0, 0, 6, 0); dchk("freeze", 1, 0, 1); adv_clk();
    end
    drive(0, 1, 0, 1, 0, 0, 0, 6, 0); dchk("freeze_rel", 1, 0, 1); adv_clk();
    drive(0, 1, 0, 1, 0, 0, 0, 6, 0); dchk("freeze_fwd", 2, 0, 0); adv_clk();
    // Reset in the middle of a stall
    drive(0, 1, 0, 1, 4, 1, 1, 0, 0); adv_clk();
    drive(0, 1, 0, 1, 0, 0, 0, 4, 0); dchk("pre_rst", 1, 0, 1);
    drive(1, 1, 0, 1, 0, 0, 0, 4, 0); adv_clk();
    drive(0, 1, 0, 1, 0, 0, 0, 4, 0); dchk("post_rst", 0, 0, 0); adv_clk();

    // Random traffic over a small register set so hits are frequent
    for (int n = 0; n < 600; n++) begin
      int r[3];
      for (int j = 0; j < 3; j++) r[j] = ($urandom_range(0, 9) == 0) ? 31 : int'($urandom_range(0, 6));
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 10,
            $urandom_range(0, 99) < 85, r[0], $urandom_range(0, 99) < 80,
            $urandom_range(0, 99) < 40, r[1], r[2]);
      adv_clk();
    end

    @(negedge clk); #1;
    chk("sb.drained", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
